instr_fetch_buffer: RTL and testbench
=====================================

# instr_fetch_buffer

Instruction fetch responder that sits between the program counter and decode. It accepts fetch addresses over a valid/ready handshake and issues word-aligned reads to a synchronous instruction memory with one-cycle read latency. Returned instructions are queued, tagged with their PC, in a small response FIFO, and a flush input discards all speculative fetches when the PC redirects on a branch, JAL or JALR.

## Interface

Parameters
- WIDTH, 32, address and instruction width
- DEPTH, 4, response FIFO entries; power of 2, at least 2

Ports
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset; asserted when 0
- req_valid  in  1  fetch address valid
- req_ready  out  1  fetch address accepted this cycle when high together with req_valid
- req_addr  in  WIDTH  fetch PC
- flush  in  1  discard all buffered and in-flight fetches (PC redirect)
- mem_en  out  1  instruction memory read enable
- mem_addr  out  WIDTH  memory read address: {req_addr[WIDTH-1:2], 2'b00}
- mem_rdata  in  WIDTH  memory read data, valid the cycle after mem_en
- rsp_valid  out  1  head FIFO entry valid
- rsp_ready  in  1  consumer takes head entry
- rsp_instr  out  WIDTH  instruction at head
- rsp_pc  out  WIDTH  PC of the head instruction
- rsp_misaligned  out  1  head entry came from a PC with addr[1:0] != 0

## Operation

- **State**
  - FIFO storage: DEPTH entries of {instr, pc, misaligned}.
  - Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count: $clog2(DEPTH)+1 bits.
  - One-stage in-flight register: inflight flag, pc, misaligned.
- **req_ready** = rst && !flush && (count + inflight < DEPTH). Space is always reserved for the in-flight read.
- **Accept** occurs when req_valid && req_ready.
  - Aligned address: mem_en=1 and mem_addr is the word-aligned address, both combinational in the accept cycle. The in-flight register loads {req_addr, 0} and inflight is set.
  - Misaligned address (req_addr[1:0] != 0): mem_en=0. The in-flight register loads {req_addr, 1} and inflight is set. The FIFO write in the next cycle stores instr = 32'h0000_0013 (NOP) in place of mem_rdata.
- **Cycle after accept**: if inflight is set, write {mem_rdata or NOP, pc, misaligned} at wr_ptr and advance wr_ptr. inflight clears unless a new accept occurs in the same cycle.
- **Pop** occurs when rsp_valid && rsp_ready; rd_ptr advances.
  - rsp_valid = (count != 0).
  - rsp_* are driven from the entry at rd_ptr.
- **Simultaneous push and pop**: count is unchanged and both pointers advance. This is allowed when full (count == DEPTH) only if a pop occurs in the same cycle. By construction, a full FIFO with inflight set cannot happen.
- **flush (synchronous)**:
  - Clears count, wr_ptr, rd_ptr and inflight at the next edge.
  - mem_rdata returning in the following cycle is dropped.
  - No accept in the flush cycle; any pop in the flush cycle is ignored.
  - The next cycle has req_ready=1.
- **Reset (asynchronous)**: immediately clears pointers, count, inflight and all FIFO storage to 0, including mid-operation. In-flight data is lost.
- **Outputs while rst=0**: req_ready=0, mem_en=0, mem_addr=0, rsp_valid=0, rsp_instr=0, rsp_pc=0, rsp_misaligned=0.

## Timing

- **Latency**: an accept in cycle C drives mem_en in cycle C, mem_rdata arrives in C+1, the FIFO write happens at the end of C+1, and rsp_valid is high in C+2. There is no bypass path.
- **Throughput**: one accept per cycle, sustained indefinitely when rsp_ready is held high.
- **Back-pressure**: with rsp_ready=0, at most DEPTH entries can be accepted. req_ready falls in the cycle where count + inflight reaches DEPTH.
- **Deassertion**: req_ready is high in the first cycle after rst deasserts.
- **Combinational paths**: mem_en and mem_addr depend combinationally on req_valid, req_addr, flush and state. rsp_* depend on registered state only.

## Test plan

- **Reset**: hold rst=0 with req_valid=1 and rsp_ready=1 -> req_ready=0, mem_en=0, rsp_valid=0 and all rsp_* are 0. After release, req_ready=1 on the first cycle.
- **Streaming**: stream PCs 0x0, 0x4, 0x8, 0xC with rsp_ready=1 and memory returning addr^32'hA5A5_0000 -> rsp_valid first high 2 cycles after the first accept. Responses come out one per cycle, in order, with matching rsp_pc and rsp_misaligned=0.
- **Full**: hold rsp_ready=0 and offer 6 requests -> exactly 4 are accepted and req_ready stays 0. Then pulse rsp_ready for 1 cycle -> one pop, then exactly one more accept.
- **Flush**: flush with 3 entries buffered and 1 in flight -> next cycle rsp_valid=0 and count=0, and the returning mem_rdata is dropped. A new request at 0x100 yields rsp_pc=0x100 two cycles later.
- **Misaligned**: req_addr=0x22 -> mem_en=0 and the response is rsp_instr=0x0000_0013, rsp_pc=0x22, rsp_misaligned=1.
- **Mid-stream reset**: assert rst=0 asynchronously mid-stream with 2 entries buffered -> rsp_valid drops without waiting for a clock edge. No stale entry appears after release.

Source files
------------

// File: rtl/instr_fetch_buffer.sv
// Purpose : fetch responder between PC and decode; issues word-aligned reads to a 1-cycle
//           synchronous instruction memory and queues {instr, pc, misaligned} in a small FIFO.
// Latency : accept in cycle C -> mem_en in C, mem_rdata in C+1, rsp_valid in C+2 (no bypass).
// Backpr. : req_ready drops once buffered entries plus the in-flight read fill DEPTH.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr  fetch PC handshake
//   flush                         PC redirect; drops buffered and in-flight fetches
//   mem_en/mem_addr/mem_rdata     instruction memory read port
//   rsp_valid/rsp_ready           response handshake
//   rsp_instr/rsp_pc/rsp_misaligned  head FIFO entry
module instr_fetch_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_addr,
    input  logic             flush,
    output logic             mem_en,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_instr,
    output logic [WIDTH-1:0] rsp_pc,
    output logic             rsp_misaligned
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc;
        logic             mis;
    } entry_t;

    entry_t           store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             inflight;
    logic [WIDTH-1:0] if_pc;
    logic             if_mis;

    logic             aligned;
    logic             accept;
    logic             push;
    logic             pop;
    logic [CW-1:0]    occupancy;
    entry_t           wr_entry;

    // The in-flight read always has a FIFO slot reserved for it, so it can
    // never find the FIFO full when its data lands.
    assign occupancy = count + CW'(inflight);
    assign req_ready = rst && !flush && (occupancy < CW'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign aligned   = (req_addr[1:0] == 2'b00);

    // Misaligned PCs never touch memory; a NOP stands in for the data.
    assign mem_en    = accept && aligned;
    assign mem_addr  = rst ? {req_addr[WIDTH-1:2], 2'b00} : '0;

    assign push      = inflight;
    assign pop       = rsp_valid && rsp_ready;

    always_comb begin
        wr_entry       = '0;
        wr_entry.instr = if_mis ? NOP : mem_rdata;
        wr_entry.pc    = if_pc;
        wr_entry.mis   = if_mis;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            if_pc    <= '0;
            if_mis   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else if (flush) begin
            // Redirect: the returning read for any in-flight fetch is dropped
            // simply by clearing inflight; storage contents are left stale.
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) begin
                if_pc  <= req_addr;
                if_mis <= !aligned;
            end
            if (push) begin
                store[wr_ptr] <= wr_entry;
                wr_ptr        <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Head outputs come straight from registered state; reset zeroes storage,
    // so these read 0 while rst is low.
    assign rsp_valid      = (count != '0);
    assign rsp_instr      = store[rd_ptr].instr;
    assign rsp_pc         = store[rd_ptr].pc;
    assign rsp_misaligned = store[rd_ptr].mis;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: scoreboard of expected responses filled on accept and
// drained on pop, plus directed timing checks for reset, streaming, full, flush,
// misaligned and mid-stream reset.
module tb_instr_fetch_buffer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_pc;
    logic        rsp_misaligned;

    instr_fetch_buffer #(.WIDTH(32), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .flush          (flush),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_instr      (rsp_instr),
        .rsp_pc         (rsp_pc),
        .rsp_misaligned (rsp_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory, one-cycle latency; garbage when not enabled.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem_addr ^ 32'hA5A5_0000;
        else        mem_rdata <= $urandom;
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_pop = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a);
        exp_t e;
        e.pc  = a;
        e.mis = (a[1:0] != 2'b00);
        e.instr = e.mis ? 32'h0000_0013 : ({a[31:2], 2'b00} ^ 32'hA5A5_0000);
        return e;
    endfunction

    // Monitor: sample mid-cycle; what it sees here takes effect at the next rising edge.
    always @(negedge clk) begin
        if (!rst || flush) begin
            sb.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_instr", rsp_instr, e.instr);
                    chk("rsp_pc", rsp_pc, e.pc);
                    chk("rsp_misaligned", {31'd0, rsp_misaligned}, {31'd0, e.mis});
                    n_pop++;
                end
            end
            if (req_valid && req_ready) begin
                chk("mem_en_on_accept", {31'd0, mem_en}, {31'd0, (req_addr[1:0] == 2'b00)});
                if (req_addr[1:0] == 2'b00)
                    chk("mem_addr", mem_addr, {req_addr[31:2], 2'b00});
                sb.push_back(model(req_addr));
                n_acc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (rsp_valid && k < 20) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int acc0;
        int pop0;
        rst       = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0040;
        flush     = 1'b0;
        rsp_ready = 1'b1;

        // ---- reset ----
        #3;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_instr", rsp_instr, 32'd0);
        chk("rst_rsp_pc", rsp_pc, 32'd0);
        chk("rst_rsp_mis", {31'd0, rsp_misaligned}, 32'd0);
        tick();
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

        // ---- streaming ----
        tick();
        pop0 = n_pop;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 32'(i * 4);
            #1;
            chk("stream_req_ready", {31'd0, req_ready}, 32'd1);
            chk("stream_mem_en", {31'd0, mem_en}, 32'd1);
            chk("stream_rsp_valid", {31'd0, rsp_valid}, (i >= 2) ? 32'd1 : 32'd0);
            tick();
        end
        req_valid = 1'b0;
        #1;
        chk("stream_rsp_valid_c4", {31'd0, rsp_valid}, 32'd1);
        tick();
        chk("stream_rsp_valid_c5", {31'd0, rsp_valid}, 32'd1);
        tick();
        drain("stream_drain");
        chk("stream_pops", 32'(n_pop - pop0), 32'd4);

        // ---- full ----
        rsp_ready = 1'b0;
        acc0 = n_acc;
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_addr = 32'h200 + 32'((n_acc - acc0) * 4);
            tick();
        end
        chk("full_accepts", 32'(n_acc - acc0), 32'd4);
        chk("full_req_ready", {31'd0, req_ready}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_addr = 32'h200 + 32'((n_acc - acc0) * 4);
            tick();
        end
        chk("full_one_more", 32'(n_acc - acc0), 32'd5);
        chk("full_req_ready_again", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain("full_drain");

        // ---- flush: 3 buffered + 1 in flight ----
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 32'h0000_0080 + 32'(i * 4);
            tick();
        end
        flush = 1'b1;
        rsp_ready = 1'b1;
        req_addr = 32'h0000_0300;
        #1;
        chk("flush_req_ready", {31'd0, req_ready}, 32'd0);
        chk("flush_mem_en", {31'd0, mem_en}, 32'd0);
        tick();
        flush = 1'b0;
        req_addr = 32'h0000_0100;
        #1;
        chk("postflush_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("postflush_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        chk("postflush_dropped", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("postflush_rsp_valid2", {31'd0, rsp_valid}, 32'd1);
        chk("postflush_rsp_pc", rsp_pc, 32'h0000_0100);
        tick();
        drain("flush_drain");

        // ---- misaligned ----
        req_valid = 1'b1;
        req_addr = 32'h0000_0022;
        #1;
        chk("mis_mem_en", {31'd0, mem_en}, 32'd0);
        chk("mis_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        tick();
        chk("mis_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("mis_rsp_instr", rsp_instr, 32'h0000_0013);
        chk("mis_rsp_pc", rsp_pc, 32'h0000_0022);
        chk("mis_rsp_mis", {31'd0, rsp_misaligned}, 32'd1);
        tick();
        drain("mis_drain");

        // ---- mid-stream asynchronous reset ----
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr = 32'h0000_0400;
        tick();
        req_addr = 32'h0000_0404;
        tick();
        req_valid = 1'b0;
        tick();
        chk("pre_reset_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("async_rsp_pc", rsp_pc, 32'd0);
        chk("async_rsp_instr", rsp_instr, 32'd0);
        chk("async_req_ready", {31'd0, req_ready}, 32'd0);
        tick();
        rst = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("post_reset_no_stale", {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        pop0 = n_pop;
        req_valid = 1'b1;
        req_addr = 32'h0000_0500;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        drain("final_drain");
        chk("final_pop", 32'(n_pop - pop0), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
